// File: rtl/dbg_ctrl_v2_if.sv
// UART byte stream bundle between the UART core (master) and the debug controller (slave).
// Latency: none, wires only.
// Backpressure: rx is a push-only pulse with no ready; tx uses valid/ready and holds data until accepted.
// Signals: rx_valid/rx_data carry host -> controller bytes; tx_valid/tx_data/tx_ready carry controller -> host bytes.
interface dbg_ctrl_v2_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_valid,
        input  tx_data
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_valid,
        output tx_data
    );
endinterface

// File: rtl/dbg_ctrl_v2.sv
// Debug controller: decodes host bytes to load imem, run or single-step the CPU, then streams a state dump.
// Latency: command byte -> state change 1 cycle; halt -> first tx byte 3 cycles; each dump word costs BPW+2 cycles.
// Backpressure: tx holds valid and data stable until tx_ready; rx bytes are dropped in states that do not consume them.
// Ports: i_clk/i_rst_n clock and async active-low reset; uart = byte stream bundle; i_cpu_* / i_reg_data / i_mem_data
//        are CPU observation buses; o_cpu_en/o_cpu_rst control the core; o_reg_sel/o_mem_addr select dumped words;
//        o_imem_* write instruction memory; o_state exposes the FSM.
// Optional feature: define BREAKPOINT_EN to add a single PC breakpoint loaded with the 'b' command.
module dbg_ctrl_v2 #(
    parameter int DATA_BITS      = 8,
    parameter int NBITS          = 32,
    parameter int NUM_REGS       = 32,
    parameter int INST_MEM_WORDS = 256,
    parameter int DUMP_BASE      = 0,
    parameter int DUMP_WORDS     = 64,
    localparam int REG_SEL       = $clog2(NUM_REGS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    dbg_ctrl_v2_if.slave       uart,
    input  logic               i_cpu_halt,
    input  logic [NBITS-1:0]   i_cpu_pc,
    input  logic [NBITS-1:0]   i_cpu_cycles,
    input  logic [NBITS-1:0]   i_reg_data,
    input  logic [NBITS-1:0]   i_mem_data,
    output logic               o_cpu_en,
    output logic               o_cpu_rst,
    output logic [REG_SEL-1:0] o_reg_sel,
    output logic [NBITS-1:0]   o_mem_addr,
    output logic               o_imem_we,
    output logic [NBITS-1:0]   o_imem_addr,
    output logic [NBITS-1:0]   o_imem_data,
    output logic [3:0]         o_state
);
    localparam int BPW         = NBITS / DATA_BITS;
    localparam int BCW         = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TOTAL_WORDS = 2 + NUM_REGS + DUMP_WORDS;
    localparam int KW          = $clog2(TOTAL_WORDS + 1);
    localparam int IW          = $clog2(INST_MEM_WORDS + 1);

    localparam logic [BCW-1:0] LAST_BYTE   = BCW'(BPW - 1);
    localparam logic [KW-1:0]  FIRST_REG_K = KW'(2);
    localparam logic [KW-1:0]  FIRST_MEM_K = KW'(2 + NUM_REGS);
    localparam logic [KW-1:0]  LAST_K      = KW'(TOTAL_WORDS - 1);
    localparam logic [IW-1:0]  LAST_INST   = IW'(INST_MEM_WORDS - 1);

    localparam logic [DATA_BITS-1:0] CMD_LOAD = DATA_BITS'(8'h6C);
    localparam logic [DATA_BITS-1:0] CMD_RUN  = DATA_BITS'(8'h72);
    localparam logic [DATA_BITS-1:0] CMD_STEP = DATA_BITS'(8'h73);
    localparam logic [DATA_BITS-1:0] CMD_NEXT = DATA_BITS'(8'h6E);
    localparam logic [DATA_BITS-1:0] CMD_QUIT = DATA_BITS'(8'h71);
`ifdef BREAKPOINT_EN
    localparam logic [DATA_BITS-1:0] CMD_BP   = DATA_BITS'(8'h62);
`endif

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD       = 4'd1,
        LOAD_WR    = 4'd2,
        RUN        = 4'd3,
        STEP_WAIT  = 4'd4,
        STEP_GO    = 4'd5,
        DUMP_SEL   = 4'd6,
        DUMP_LATCH = 4'd7,
        DUMP_TX    = 4'd8,
        BP_LOAD    = 4'd9
    } state_t;

    state_t           state;
    state_t           ret_state;
    logic [BCW-1:0]   byte_cnt;
    logic [KW-1:0]    word_idx;
    logic [IW-1:0]    inst_cnt;
    logic [NBITS-1:0] shift_word;
    logic [NBITS-1:0] rx_shifted;
    logic [NBITS-1:0] dump_word;
    logic [NBITS-1:0] latch_word;
    logic             tx_valid;
    logic             tx_fire;
    logic             bp_hit;
    logic             dump_go;
    logic [KW-1:0]    sel_k;

    // Incoming bytes fill the word MSB-first.
    if (BPW > 1) begin : g_shift
        assign rx_shifted = {shift_word[NBITS-DATA_BITS-1:0], uart.rx_data};
    end else begin : g_noshift
        assign rx_shifted = uart.rx_data;
    end

`ifdef BREAKPOINT_EN
    logic [NBITS-1:0] bp_addr;
    logic             bp_valid;
    assign bp_hit = bp_valid && (i_cpu_pc == bp_addr) && (state == RUN);
`else
    assign bp_hit = 1'b0;
`endif

    assign tx_fire = tx_valid & uart.tx_ready;

    // Combinational so the core is gated in the same cycle halt/breakpoint is seen.
    assign o_cpu_en = ((state == RUN) && !i_cpu_halt && !bp_hit) || (state == STEP_GO);

    assign uart.tx_valid = tx_valid;
    assign uart.tx_data  = dump_word[NBITS-1 -: DATA_BITS];
    assign o_state       = state;

    // dump_go marks every transition into DUMP_SEL; sel_k is the word index being entered.
    // The selects are registered on that transition so they are already stable during DUMP_SEL,
    // giving synchronous-read sources a full cycle before DUMP_LATCH samples them.
    always_comb begin
        dump_go = 1'b0;
        sel_k   = '0;
        case (state)
            RUN:       dump_go = i_cpu_halt | bp_hit;
            STEP_WAIT: dump_go = i_cpu_halt;
            STEP_GO:   dump_go = 1'b1;
            DUMP_TX: begin
                dump_go = tx_fire && (byte_cnt == LAST_BYTE) && (word_idx != LAST_K);
                sel_k   = word_idx + KW'(1);
            end
            default:   dump_go = 1'b0;
        endcase
    end

    always_comb begin
        if (word_idx == '0) begin
            latch_word = i_cpu_pc;
        end else if (word_idx == KW'(1)) begin
            latch_word = i_cpu_cycles;
        end else if (word_idx < FIRST_MEM_K) begin
            latch_word = i_reg_data;
        end else begin
            latch_word = i_mem_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            ret_state   <= IDLE;
            byte_cnt    <= '0;
            word_idx    <= '0;
            inst_cnt    <= '0;
            shift_word  <= '0;
            dump_word   <= '0;
            tx_valid    <= 1'b0;
            o_cpu_rst   <= 1'b1;
            o_reg_sel   <= '0;
            o_mem_addr  <= '0;
            o_imem_we   <= 1'b0;
            o_imem_addr <= '0;
            o_imem_data <= '0;
`ifdef BREAKPOINT_EN
            bp_addr     <= '0;
            bp_valid    <= 1'b0;
`endif
        end else begin
            o_cpu_rst <= 1'b0;
            o_imem_we <= 1'b0;

            // Selects only move inside a dump, so they hold their last value otherwise.
            if (dump_go) begin
                if (sel_k >= FIRST_REG_K && sel_k < FIRST_MEM_K) begin
                    o_reg_sel <= REG_SEL'(sel_k - FIRST_REG_K);
                end else if (sel_k >= FIRST_MEM_K) begin
                    o_mem_addr <= NBITS'(DUMP_BASE) + NBITS'(sel_k - FIRST_MEM_K) * NBITS'(BPW);
                end
            end

            case (state)
                IDLE: begin
                    if (uart.rx_valid) begin
                        byte_cnt <= '0;
                        case (uart.rx_data)
                            CMD_LOAD: state <= LOAD;
                            CMD_RUN: begin
                                state     <= RUN;
                                o_cpu_rst <= 1'b1;
                            end
                            CMD_STEP: begin
                                state     <= STEP_WAIT;
                                o_cpu_rst <= 1'b1;
                            end
`ifdef BREAKPOINT_EN
                            CMD_BP:   state <= BP_LOAD;
`endif
                            default:  state <= IDLE;
                        endcase
                    end
                end

                LOAD: begin
                    if (uart.rx_valid) begin
                        shift_word <= rx_shifted;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt    <= '0;
                            o_imem_data <= rx_shifted;
                            o_imem_we   <= 1'b1;
                            state       <= LOAD_WR;
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end

                LOAD_WR: begin
                    // An all-ones word is the halt instruction and terminates the program.
                    if ((&o_imem_data) || (inst_cnt == LAST_INST)) begin
                        o_imem_addr <= '0;
                        inst_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        o_imem_addr <= o_imem_addr + NBITS'(BPW);
                        inst_cnt    <= inst_cnt + IW'(1);
                        state       <= LOAD;
                    end
                end

                RUN: begin
                    if (dump_go) begin
                        ret_state <= IDLE;
                        word_idx  <= '0;
                        state     <= DUMP_SEL;
                    end
                end

                STEP_WAIT: begin
                    // Halt takes priority over a byte arriving in the same cycle.
                    if (i_cpu_halt) begin
                        ret_state <= IDLE;
                        word_idx  <= '0;
                        state     <= DUMP_SEL;
                    end else if (uart.rx_valid) begin
                        if (uart.rx_data == CMD_NEXT) begin
                            state <= STEP_GO;
                        end else if (uart.rx_data == CMD_QUIT) begin
                            state <= IDLE;
                        end
                    end
                end

                STEP_GO: begin
                    ret_state <= STEP_WAIT;
                    word_idx  <= '0;
                    state     <= DUMP_SEL;
                end

                DUMP_SEL: state <= DUMP_LATCH;

                DUMP_LATCH: begin
                    dump_word <= latch_word;
                    byte_cnt  <= '0;
                    tx_valid  <= 1'b1;
                    state     <= DUMP_TX;
                end

                DUMP_TX: begin
                    if (tx_fire) begin
                        if (byte_cnt == LAST_BYTE) begin
                            tx_valid <= 1'b0;
                            byte_cnt <= '0;
                            if (word_idx == LAST_K) begin
                                state <= ret_state;
                            end else begin
                                word_idx <= sel_k;
                                state    <= DUMP_SEL;
                            end
                        end else begin
                            dump_word <= dump_word << DATA_BITS;
                            byte_cnt  <= byte_cnt + BCW'(1);
                        end
                    end
                end

`ifdef BREAKPOINT_EN
                BP_LOAD: begin
                    if (uart.rx_valid) begin
                        shift_word <= rx_shifted;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            bp_addr  <= rx_shifted;
                            bp_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end
endmodule
